// File: rtl/global_dep_manager_pkg.sv
// Shared types for the global dependency manager: slot state and conflict flags.
package svm_sched_pkg;

    localparam int DEFAULT_MAX_DEPENDENCIES = 256;

    typedef enum logic {
        SLOT_FREE   = 1'b0,
        SLOT_ACTIVE = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic raw;
        logic waw;
        logic war;
    } conflict_t;

endpackage

// File: rtl/global_dep_manager_dep_slot.sv
// One in-flight batch slot: FREE/ACTIVE state, stored dependency unions and
// a combinational RAW/WAW/WAR compare against the current query.
module dep_slot
    import svm_sched_pkg::*;
#(
    parameter int DEP_W = DEFAULT_MAX_DEPENDENCIES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_i,
    input  logic             free_i,
    input  logic [DEP_W-1:0] wr_read_deps_i,
    input  logic [DEP_W-1:0] wr_write_deps_i,
    input  logic [63:0]      wr_owner_i,
    input  logic [DEP_W-1:0] q_read_deps_i,
    input  logic [DEP_W-1:0] q_write_deps_i,
    input  logic [63:0]      q_owner_i,
    output logic             active_o,
    output conflict_t        flags_o
);

    slot_state_e      state_q, state_d;
    logic [DEP_W-1:0] read_q;
    logic [DEP_W-1:0] write_q;
    logic [63:0]      owner_q;
    logic             contend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_FREE;
            read_q  <= '0;
            write_q <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            if (alloc_i) begin
                read_q  <= wr_read_deps_i;
                write_q <= wr_write_deps_i;
                owner_q <= wr_owner_i;
            end
        end
    end

    // alloc only reaches a FREE slot and free only an ACTIVE one, so they never collide
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_FREE:   if (alloc_i) state_d = SLOT_ACTIVE;
            SLOT_ACTIVE: if (free_i)  state_d = SLOT_FREE;
        endcase
    end

    assign active_o    = (state_q == SLOT_ACTIVE);
    assign contend     = active_o && (owner_q != q_owner_i);
    assign flags_o.raw = contend && |(q_read_deps_i  & write_q);
    assign flags_o.waw = contend && |(q_write_deps_i & write_q);
    assign flags_o.war = contend && |(q_write_deps_i & read_q);

endmodule

// File: rtl/global_dep_manager.sv
// Tracks dependency unions of in-flight batches and answers one-cycle-latency
// conflict queries; slots are allocated lowest-free-first and freed on retirement.
module global_dep_manager
    import svm_sched_pkg::*;
#(
    parameter int  MAX_DEPENDENCIES     = DEFAULT_MAX_DEPENDENCIES,
    parameter int  MAX_INFLIGHT_BATCHES = 4,
    localparam int SLOT_W               = $clog2(MAX_INFLIGHT_BATCHES)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            reg_valid,
    output logic                            reg_ready,
    input  logic [MAX_DEPENDENCIES-1:0]     reg_read_deps,
    input  logic [MAX_DEPENDENCIES-1:0]     reg_write_deps,
    input  logic [63:0]                     reg_owner_id,
    output logic [SLOT_W-1:0]               reg_slot,
    input  logic                            rel_valid,
    input  logic [SLOT_W-1:0]               rel_slot,
    input  logic                            q_valid,
    input  logic [MAX_DEPENDENCIES-1:0]     q_read_deps,
    input  logic [MAX_DEPENDENCIES-1:0]     q_write_deps,
    input  logic [63:0]                     q_owner_id,
    output logic                            r_valid,
    output logic                            r_conflict,
    output logic                            r_raw,
    output logic                            r_waw,
    output logic                            r_war,
    output logic [MAX_INFLIGHT_BATCHES-1:0] r_slot_mask,
    output logic [SLOT_W:0]                 inflight_count,
    output logic [31:0]                     rel_error_count
);

    localparam int N = MAX_INFLIGHT_BATCHES;

    logic [N-1:0]      slot_active;
    logic [N-1:0]      slot_alloc;
    logic [N-1:0]      slot_free;
    conflict_t         slot_flags [N];
    logic [SLOT_W-1:0] alloc_idx;
    logic              alloc_found;
    logic              alloc;
    logic              rel_ok;
    logic              rel_bad;
    conflict_t         agg_flags;
    logic [N-1:0]      agg_mask;

    logic [SLOT_W:0]   count_q, count_d;
    logic [31:0]       err_q, err_d;
    logic              r_valid_q;
    conflict_t         r_flags_q;
    logic [N-1:0]      r_mask_q;

    for (genvar i = 0; i < N; i++) begin : g_slot
        assign slot_alloc[i] = alloc  && (alloc_idx == SLOT_W'(i));
        assign slot_free[i]  = rel_ok && (rel_slot  == SLOT_W'(i));

        dep_slot #(.DEP_W(MAX_DEPENDENCIES)) u_slot (
            .clk             (clk),
            .rst             (rst),
            .alloc_i         (slot_alloc[i]),
            .free_i          (slot_free[i]),
            .wr_read_deps_i  (reg_read_deps),
            .wr_write_deps_i (reg_write_deps),
            .wr_owner_i      (reg_owner_id),
            .q_read_deps_i   (q_read_deps),
            .q_write_deps_i  (q_write_deps),
            .q_owner_i       (q_owner_id),
            .active_o        (slot_active[i]),
            .flags_o         (slot_flags[i])
        );
    end

    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!slot_active[i] && !alloc_found) begin
                alloc_idx   = SLOT_W'(i);
                alloc_found = 1'b1;
            end
        end
    end

    assign reg_ready = (count_q < (SLOT_W+1)'(N));
    assign reg_slot  = alloc_idx;
    assign alloc     = reg_valid && reg_ready;
    assign rel_ok    = rel_valid &&  slot_active[rel_slot];
    assign rel_bad   = rel_valid && !slot_active[rel_slot];

    always_comb begin
        count_d = count_q;
        case ({alloc, rel_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        err_d = err_q;
        if (rel_bad && (err_q != '1)) err_d = err_q + 1'b1;
    end

    always_comb begin
        agg_flags = '0;
        agg_mask  = '0;
        for (int i = 0; i < N; i++) begin
            agg_flags.raw = agg_flags.raw | slot_flags[i].raw;
            agg_flags.waw = agg_flags.waw | slot_flags[i].waw;
            agg_flags.war = agg_flags.war | slot_flags[i].war;
            agg_mask[i]   = |slot_flags[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            err_q     <= '0;
            r_valid_q <= 1'b0;
            r_flags_q <= '0;
            r_mask_q  <= '0;
        end else begin
            count_q   <= count_d;
            err_q     <= err_d;
            r_valid_q <= q_valid;
            if (q_valid) begin
                r_flags_q <= agg_flags;
                r_mask_q  <= agg_mask;
            end
        end
    end

    assign r_valid         = r_valid_q;
    assign r_raw           = r_flags_q.raw;
    assign r_waw           = r_flags_q.waw;
    assign r_war           = r_flags_q.war;
    assign r_slot_mask     = r_mask_q;
    assign r_conflict      = |r_mask_q;
    assign inflight_count  = count_q;
    assign rel_error_count = err_q;

endmodule

// File: tb/tb_global_dep_manager.sv
// Randomised plus directed bench for global_dep_manager with a queue scoreboard
// fed by a table-level reference model.
module tb_global_dep_manager;

    localparam int DW = 256;
    localparam int NS = 4;

    typedef struct packed {
        logic [NS-1:0] mask;
        logic          raw;
        logic          waw;
        logic          war;
        logic          conflict;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reg_valid = 1'b0;
    logic          reg_ready;
    logic [DW-1:0] reg_read_deps = '0;
    logic [DW-1:0] reg_write_deps = '0;
    logic [63:0]   reg_owner_id = '0;
    logic [1:0]    reg_slot;
    logic          rel_valid = 1'b0;
    logic [1:0]    rel_slot = '0;
    logic          q_valid = 1'b0;
    logic [DW-1:0] q_read_deps = '0;
    logic [DW-1:0] q_write_deps = '0;
    logic [63:0]   q_owner_id = '0;
    logic          r_valid, r_conflict, r_raw, r_waw, r_war;
    logic [NS-1:0] r_slot_mask;
    logic [2:0]    inflight_count;
    logic [31:0]   rel_error_count;

    global_dep_manager dut (
        .clk             (clk),
        .rst             (rst),
        .reg_valid       (reg_valid),
        .reg_ready       (reg_ready),
        .reg_read_deps   (reg_read_deps),
        .reg_write_deps  (reg_write_deps),
        .reg_owner_id    (reg_owner_id),
        .reg_slot        (reg_slot),
        .rel_valid       (rel_valid),
        .rel_slot        (rel_slot),
        .q_valid         (q_valid),
        .q_read_deps     (q_read_deps),
        .q_write_deps    (q_write_deps),
        .q_owner_id      (q_owner_id),
        .r_valid         (r_valid),
        .r_conflict      (r_conflict),
        .r_raw           (r_raw),
        .r_waw           (r_waw),
        .r_war           (r_war),
        .r_slot_mask     (r_slot_mask),
        .inflight_count  (inflight_count),
        .rel_error_count (rel_error_count)
    );

    always #5 clk = ~clk;

    // reference table: which batches are in flight and what they touch
    logic          m_active [NS];
    logic [DW-1:0] m_rd     [NS];
    logic [DW-1:0] m_wr     [NS];
    logic [63:0]   m_own    [NS];
    logic [31:0]   m_err;
    resp_t         sb_q [$];
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] bit_at(input int i);
        logic [DW-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] rnd_deps();
        logic [DW-1:0] v;
        v = '0;
        if ($urandom_range(0, 4) != 0)
            repeat (3) v[$urandom_range(0, 15)] = 1'b1;
        return v;
    endfunction

    function automatic resp_t model_query(input logic [DW-1:0] qr, input logic [DW-1:0] qw,
                                          input logic [63:0] qo);
        resp_t r;
        logic  a, b, c;
        r = '0;
        for (int s = 0; s < NS; s++) begin
            if (m_active[s] && m_own[s] != qo) begin
                a = |(qr & m_wr[s]);
                b = |(qw & m_wr[s]);
                c = |(qw & m_rd[s]);
                r.mask[s] = a | b | c;
                r.raw = r.raw | a;
                r.waw = r.waw | b;
                r.war = r.war | c;
            end
        end
        r.conflict = |r.mask;
        return r;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < NS; s++) begin
            m_active[s] = 1'b0;
            m_rd[s] = '0;
            m_wr[s] = '0;
            m_own[s] = '0;
        end
        m_err = '0;
    endtask

    task automatic idle();
        reg_valid = 1'b0;
        rel_valid = 1'b0;
        q_valid   = 1'b0;
    endtask

    // one clock cycle: check table-side outputs at negedge, then advance the model at posedge
    task automatic tick();
        int cnt;
        int fidx;
        cnt  = 0;
        fidx = -1;
        @(negedge clk);
        for (int s = 0; s < NS; s++) begin
            if (m_active[s]) cnt++;
            else if (fidx < 0) fidx = s;
        end
        chk("reg_ready", 64'(reg_ready), 64'(cnt < NS));
        chk("inflight_count", 64'(inflight_count), 64'(cnt));
        chk("rel_error_count", 64'(rel_error_count), 64'(m_err));
        if (reg_valid && cnt < NS) chk("reg_slot", 64'(reg_slot), 64'(fidx));
        @(posedge clk);
        if (q_valid) sb_q.push_back(model_query(q_read_deps, q_write_deps, q_owner_id));
        if (rel_valid) begin
            if (m_active[rel_slot]) m_active[rel_slot] = 1'b0;
            else if (m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
        end
        if (reg_valid && cnt < NS) begin
            m_active[fidx] = 1'b1;
            m_rd[fidx]     = reg_read_deps;
            m_wr[fidx]     = reg_write_deps;
            m_own[fidx]    = reg_owner_id;
        end
        #1;
    endtask

    task automatic do_reg(input logic [DW-1:0] rd, input logic [DW-1:0] wr, input logic [63:0] own);
        reg_valid = 1'b1; reg_read_deps = rd; reg_write_deps = wr; reg_owner_id = own;
        tick();
        reg_valid = 1'b0;
    endtask

    task automatic do_query(input logic [DW-1:0] rd, input logic [DW-1:0] wr, input logic [63:0] own);
        q_valid = 1'b1; q_read_deps = rd; q_write_deps = wr; q_owner_id = own;
        tick();
        q_valid = 1'b0;
    endtask

    task automatic do_rel(input logic [1:0] s);
        rel_valid = 1'b1; rel_slot = s;
        tick();
        rel_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        resp_t e;
        resp_t a;
        if (!rst) begin
            a = {r_slot_mask, r_raw, r_waw, r_war, r_conflict};
            if (r_valid) begin
                if (sb_q.size() == 0) begin
                    chk("r_valid_unexpected", 64'(r_valid), 64'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("query_result", 64'(a), 64'(e));
                end
            end else if (sb_q.size() != 0) begin
                void'(sb_q.pop_front());
                chk("r_valid_missing", 64'(r_valid), 64'(1));
            end
        end
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_r_valid", 64'(r_valid), 64'(0));
        chk("rst_r_conflict", 64'(r_conflict), 64'(0));
        chk("rst_r_flags", 64'({r_raw, r_waw, r_war}), 64'(0));
        chk("rst_r_slot_mask", 64'(r_slot_mask), 64'(0));
        chk("rst_inflight", 64'(inflight_count), 64'(0));
        chk("rst_rel_err", 64'(rel_error_count), 64'(0));
        chk("rst_reg_ready", 64'(reg_ready), 64'(1));
        @(posedge clk); #1;

        // batch A in slot 0, then RAW / same-owner / WAW queries
        do_reg('0, bit_at(5), 64'd1);
        do_query(bit_at(5), '0, 64'd2);
        do_query(bit_at(5), '0, 64'd1);
        do_query('0, bit_at(5), 64'd2);
        do_reg(bit_at(9), '0, 64'd1);
        do_query('0, bit_at(9), 64'd2);
        do_rel(2'd0);
        do_rel(2'd1);
        tick();

        // fill table, then release slot 2 with reg_valid held
        reg_valid = 1'b1;
        for (int i = 0; i < NS; i++) begin
            reg_read_deps = rnd_deps(); reg_write_deps = rnd_deps(); reg_owner_id = 64'(i + 10);
            tick();
        end
        tick();
        chk("full_inflight", 64'(inflight_count), 64'(4));
        chk("full_ready", 64'(reg_ready), 64'(0));
        rel_valid = 1'b1; rel_slot = 2'd2;
        tick();
        rel_valid = 1'b0;
        chk("post_rel_ready", 64'(reg_ready), 64'(1));
        chk("post_rel_slot", 64'(reg_slot), 64'(2));
        tick();
        reg_valid = 1'b0;

        // free slot 3 then release it twice more
        do_rel(2'd3);
        do_rel(2'd3);
        do_rel(2'd3);
        chk("double_rel_err", 64'(rel_error_count), 64'(2));
        for (int s = 0; s < 3; s++) do_rel(2'(s));
        tick();

        // same-edge registration is invisible to the query; a repeat sees it
        reg_valid = 1'b1; reg_read_deps = '0; reg_write_deps = bit_at(7); reg_owner_id = 64'd6;
        q_valid = 1'b1; q_read_deps = bit_at(7); q_write_deps = '0; q_owner_id = 64'd5;
        tick();
        reg_valid = 1'b0;
        tick();
        q_valid = 1'b0;

        // three active, conflicting query outstanding, then asynchronous reset
        do_reg(bit_at(3), bit_at(4), 64'd7);
        do_reg('0, bit_at(8), 64'd8);
        q_valid = 1'b1; q_read_deps = bit_at(4); q_write_deps = '0; q_owner_id = 64'd9;
        tick();
        idle();
        #2 rst = 1'b1;
        sb_q.delete();
        model_clear();
        #1;
        chk("async_rst_inflight", 64'(inflight_count), 64'(0));
        chk("async_rst_r_valid", 64'(r_valid), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        do_query(bit_at(4), '0, 64'd9);
        tick();

        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            reg_valid      = ($urandom_range(0, 1) == 1);
            reg_read_deps  = rnd_deps();
            reg_write_deps = rnd_deps();
            reg_owner_id   = 64'($urandom_range(0, 3));
            rel_valid      = ($urandom_range(0, 9) < 3);
            rel_slot       = 2'($urandom_range(0, 3));
            q_valid        = ($urandom_range(0, 9) < 6);
            q_read_deps    = rnd_deps();
            q_write_deps   = rnd_deps();
            q_owner_id     = 64'($urandom_range(0, 3));
            tick();
        end
        idle();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
